decodificador: RTL and testbench
================================

DECODIFICADOR -- requirements
Module: decodificador

Interface
REQ-001 Parameter ERR_W, default 8: width of the invalid-code counter; legal range 4..16.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 In_Code  input  4  excess-3 code word from the upstream encoder.
REQ-005 In_Valid  input  1  In_Code is valid this cycle.
REQ-006 In_Ready  output  1  block can accept a code word this cycle.
REQ-007 Out_Digit  output  4  decoded BCD digit 0..9.
REQ-008 Out_Err  output  1  held word was not a legal excess-3 code.
REQ-009 Out_Valid  output  1  Out_Digit/Out_Err hold a word.
REQ-010 Out_Ready  input  1  downstream accepts the held word.
REQ-011 Display  output  7  segments {a,b,c,d,e,f,g} = Display[6:0], active-high.
REQ-012 Err_Count  output  ERR_W  saturating invalid-code counter (present only per REQ-030).

Function
REQ-013 Input transfer occurs on a cycle with In_Valid=1 and In_Ready=1; output transfer on a cycle with Out_Valid=1 and Out_Ready=1.
REQ-014 Single-entry pipeline register, state EMPTY or FULL; In_Ready = (state==EMPTY) | Out_Ready, combinational.
REQ-015 EMPTY + input transfer -> FULL; FULL + output transfer with no input transfer -> EMPTY; FULL + both transfers -> FULL holding the new word; otherwise state is held.
REQ-016 Latency: a word accepted in cycle N is presented with Out_Valid=1 in cycle N+1.
REQ-017 Out_Valid = (state==FULL); Out_Digit/Out_Err stay stable while Out_Valid=1 and Out_Ready=0.
REQ-018 Legal codes 0011..1100 decode to In_Code minus 3 (4-bit), with Out_Err=0.
REQ-019 Codes 0000, 0001, 0010, 1101, 1110 and 1111 store Out_Digit=0000 and Out_Err=1.
REQ-020 Display updates only on an output transfer; it shows the transferred digit, or pattern E when Out_Err=1.
REQ-021 Patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, E=1001111, blank=0000000.
REQ-022 Display holds its last value between transfers; EMPTY state does not blank it.
REQ-023 In_Code is ignored on any cycle without an input transfer.

Reset
REQ-024 Reset_n low forces immediately: state=EMPTY, Out_Valid=0, Out_Digit=0000, Out_Err=0, Display=0000000 (blank), Err_Count=0.
REQ-025 In_Ready is 1 while in reset and in the first cycle after release.
REQ-026 Reset asserted mid-transfer discards the held word; no output transfer is reported for it.
REQ-027 Reset release is synchronised by the integrator; the block assumes release is clean with respect to Clock.

Configuration
REQ-028 Macro DECODIFICADOR_ERRCNT_EN selects the error-counter feature.
REQ-029 Defined: Err_Count increments by 1 on each input transfer of an illegal code and saturates at all-ones.
REQ-030 Undefined: the Err_Count port and its logic are absent, and all other behaviour is identical.

Verification
REQ-031 Reset, then In_Code=0111 with In_Valid=1 and Out_Ready=1 -> next cycle Out_Valid=1, Out_Digit=0100, Out_Err=0; cycle after that Display=0110011.
REQ-032 Sweep all 16 codes with Out_Ready=1 -> 0011..1100 give digits 0..9; the six illegal codes give Out_Err=1, Out_Digit=0, Display=1001111.
REQ-033 Fill with 1000 and hold Out_Ready=0 for 5 cycles -> In_Ready=0, Out_Digit stays 0101, Display unchanged; then Out_Ready=1 with In_Valid=1, In_Code=1100 -> same-cycle replace, next Out_Digit=1001.
REQ-034 With the macro defined, with ERR_W=4, apply 20 input transfers of 1111 -> Err_Count=1111 (saturated); without the macro, no Err_Count port exists.
REQ-035 Pull Reset_n low while FULL with Out_Ready=0 -> Out_Valid=0 and Display=0000000 immediately, without a clock edge; In_Ready=1.

Source files
------------

// File: rtl/decodificador.sv
//------------------------------------------------------------------------------
// decodificador
//   Excess-3 to BCD decoder with a single-entry valid/ready pipeline register,
//   an error flag for illegal code words and a registered 7-segment display
//   that updates only when a word is handed downstream.
//   Optional feature: define DECODIFICADOR_ERRCNT_EN to add the saturating
//   Err_Count output counting input transfers of illegal code words.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decodificador #(
   parameter int ERR_W = 8
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [3:0]       In_Code,
   input  logic             In_Valid,
   output logic             In_Ready,
   output logic [3:0]       Out_Digit,
   output logic             Out_Err,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [6:0]       Display
`ifdef DECODIFICADOR_ERRCNT_EN
   ,
   output logic [ERR_W-1:0] Err_Count
`endif
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [6:0] C_SEG_BLANK = 7'b0000000;
   localparam logic [6:0] C_SEG_E     = 7'b1001111;

   // Reject counter widths outside the supported range at elaboration
   generate
      if (ERR_W < 4 || ERR_W > 16) begin : g_err_w_range
         $error("decodificador: ERR_W must be within 4..16");
      end
   endgenerate

   state_t     r_state;
   logic [3:0] r_digit;
   logic       r_err;
   logic [6:0] r_display;

   logic       w_in_xfer;
   logic       w_out_xfer;
   logic       w_code_legal;
   logic [3:0] w_code_digit;

   // Segment pattern {a,b,c,d,e,f,g} for a BCD digit; non-digits show blank
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'b1111110;
         4'd1:    pat = 7'b0110000;
         4'd2:    pat = 7'b1101101;
         4'd3:    pat = 7'b1111001;
         4'd4:    pat = 7'b0110011;
         4'd5:    pat = 7'b1011011;
         4'd6:    pat = 7'b1011111;
         4'd7:    pat = 7'b1110000;
         4'd8:    pat = 7'b1111111;
         4'd9:    pat = 7'b1111011;
         default: pat = C_SEG_BLANK;
      endcase
      return pat;
   endfunction

   // Handshake: the register can take a word when empty or when it drains now
   assign In_Ready   = (r_state == ST_EMPTY) | Out_Ready;
   assign Out_Valid  = (r_state == ST_FULL);
   assign w_in_xfer  = In_Valid & In_Ready;
   assign w_out_xfer = Out_Valid & Out_Ready;

   // Excess-3 decode: only 0011..1100 are legal, everything else flags an error
   assign w_code_legal = (In_Code >= 4'd3) && (In_Code <= 4'd12);
   assign w_code_digit = w_code_legal ? (In_Code - 4'd3) : 4'd0;

   assign Out_Digit = r_digit;
   assign Out_Err   = r_err;
   assign Display   = r_display;

   // Pipeline state, held word and display register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_EMPTY;
         r_digit   <= 4'd0;
         r_err     <= 1'b0;
         r_display <= C_SEG_BLANK;
      end else begin
         // Display latches the word being handed over, before it is replaced
         if (w_out_xfer) begin
            r_display <= r_err ? C_SEG_E : seg_pattern(r_digit);
         end
         if (w_in_xfer) begin
            r_state <= ST_FULL;
            r_digit <= w_code_digit;
            r_err   <= ~w_code_legal;
         end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
         end
      end
   end

`ifdef DECODIFICADOR_ERRCNT_EN
   logic [ERR_W-1:0] r_err_count;

   assign Err_Count = r_err_count;

   // Count accepted illegal words, sticking at all-ones
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_err_count <= '0;
      end else if (w_in_xfer && !w_code_legal && (r_err_count != {ERR_W{1'b1}})) begin
         r_err_count <= r_err_count + 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decodificador.sv
//------------------------------------------------------------------------------
// tb_decodificador
//   Self-checking bench for decodificador: directed scenarios plus randomized
//   traffic compared against a behavioural reference model.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decodificador;

   localparam int TB_ERR_W = 4;

   localparam logic [6:0] SEG [0:10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
      7'b1001111
   };

   logic                Clock = 1'b0;
   logic                Reset_n;
   logic [3:0]          In_Code;
   logic                In_Valid;
   logic                In_Ready;
   logic [3:0]          Out_Digit;
   logic                Out_Err;
   logic                Out_Valid;
   logic                Out_Ready;
   logic [6:0]          Display;
`ifdef DECODIFICADOR_ERRCNT_EN
   logic [TB_ERR_W-1:0] Err_Count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   bit       m_full;
   int       m_digit;
   bit       m_err;
   int       m_disp;
   int       m_cnt;

   decodificador #(.ERR_W(TB_ERR_W)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .In_Code   (In_Code),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .Out_Digit (Out_Digit),
      .Out_Err   (Out_Err),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Display   (Display)
`ifdef DECODIFICADOR_ERRCNT_EN
      ,
      .Err_Count (Err_Count)
`endif
   );

   always #5 Clock = ~Clock;

   function automatic void model_reset();
      m_full = 0; m_digit = 0; m_err = 0; m_disp = 0; m_cnt = 0;
   endfunction

   // drive inputs and let combinational paths settle (called at posedge+1)
   task automatic apply(input logic [3:0] code, input logic valid, input logic ordy);
      In_Code = code; In_Valid = valid; Out_Ready = ordy;
      #1;
   endtask

   // advance one clock, updating the model from the current inputs
   task automatic tick();
      bit in_x, out_x, legal;
      int code;
      code  = In_Code;
      in_x  = In_Valid && (!m_full || Out_Ready);
      out_x = m_full && Out_Ready;
      legal = (code >= 3) && (code <= 12);
      @(posedge Clock);
      #1;
      if (out_x) m_disp = m_err ? SEG[10] : SEG[m_digit];
      if (in_x) begin
         m_full  = 1;
         m_digit = legal ? code - 3 : 0;
         m_err   = !legal;
         if (!legal && m_cnt < (1 << TB_ERR_W) - 1) m_cnt++;
      end else if (out_x) begin
         m_full = 0;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; In_Code = 4'd0; In_Valid = 1'b0; Out_Ready = 1'b0;
      model_reset();
      #2;
      n_checks++; if (Out_Valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", Out_Valid); else n_pass++;
      n_checks++; if (Out_Digit !== 4'd0) $display("FAIL reset_out_digit: got %b want 0000", Out_Digit); else n_pass++;
      n_checks++; if (Out_Err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", Out_Err); else n_pass++;
      n_checks++; if (Display !== 7'd0) $display("FAIL reset_display: got %b want 0000000", Display); else n_pass++;
      n_checks++; if (In_Ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", In_Ready); else n_pass++;
`ifdef DECODIFICADOR_ERRCNT_EN
      n_checks++; if (Err_Count !== '0) $display("FAIL reset_err_count: got %h want 0", Err_Count); else n_pass++;
`endif
      @(posedge Clock); @(posedge Clock); #1;
      Reset_n = 1'b1;
      #1;
      n_checks++; if (In_Ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", In_Ready); else n_pass++;
   endtask

   task automatic test_basic();
      apply(4'b0111, 1'b1, 1'b1);
      tick();
      apply(4'b0000, 1'b0, 1'b1);
      n_checks++; if (Out_Valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", Out_Valid); else n_pass++;
      n_checks++; if (Out_Digit !== 4'b0100) $display("FAIL basic_out_digit: got %b want 0100", Out_Digit); else n_pass++;
      n_checks++; if (Out_Err !== 1'b0) $display("FAIL basic_out_err: got %b want 0", Out_Err); else n_pass++;
      tick();
      n_checks++; if (Display !== 7'b0110011) $display("FAIL basic_display: got %b want 0110011", Display); else n_pass++;
      n_checks++; if (Out_Valid !== 1'b0) $display("FAIL basic_drained: got %b want 0", Out_Valid); else n_pass++;
   endtask

   task automatic test_sweep();
      for (int c = 0; c <= 16; c++) begin
         apply(4'(c), (c < 16), 1'b1);
         if (c > 0) begin
            n_checks++; if (Out_Digit !== 4'(m_digit) || Out_Err !== m_err || Out_Valid !== 1'b1)
               $display("FAIL sweep_word code=%0d: got digit=%0d err=%b vld=%b want digit=%0d err=%b vld=1",
                        c - 1, Out_Digit, Out_Err, Out_Valid, m_digit, m_err);
            else n_pass++;
         end
         n_checks++; if (Display !== 7'(m_disp)) $display("FAIL sweep_display step=%0d: got %b want %b", c, Display, 7'(m_disp)); else n_pass++;
         tick();
      end
      apply(4'd0, 1'b0, 1'b1);
      n_checks++; if (Display !== 7'b1001111) $display("FAIL sweep_last_display: got %b want 1001111", Display); else n_pass++;
   endtask

   task automatic test_stall();
      logic [6:0] disp_before;
      apply(4'b1000, 1'b1, 1'b0);
      tick();
      disp_before = Display;
      for (int i = 0; i < 5; i++) begin
         apply(4'($urandom_range(0, 15)), 1'b1, 1'b0);
         n_checks++; if (In_Ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d: got %b want 0", i, In_Ready); else n_pass++;
         tick();
         n_checks++; if (Out_Digit !== 4'b0101 || Out_Valid !== 1'b1) $display("FAIL stall_hold cyc=%0d: got digit=%b vld=%b want 0101 1", i, Out_Digit, Out_Valid); else n_pass++;
         n_checks++; if (Display !== disp_before) $display("FAIL stall_display cyc=%0d: got %b want %b", i, Display, disp_before); else n_pass++;
      end
      apply(4'b1100, 1'b1, 1'b1);
      n_checks++; if (In_Ready !== 1'b1) $display("FAIL replace_in_ready: got %b want 1", In_Ready); else n_pass++;
      tick();
      apply(4'd0, 1'b0, 1'b0);
      n_checks++; if (Out_Digit !== 4'b1001 || Out_Valid !== 1'b1) $display("FAIL replace_digit: got %b vld=%b want 1001 1", Out_Digit, Out_Valid); else n_pass++;
      n_checks++; if (Display !== 7'b1011011) $display("FAIL replace_display: got %b want 1011011", Display); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
         n_checks++; if (In_Ready !== (!m_full || Out_Ready)) $display("FAIL rand_in_ready i=%0d: got %b want %b", i, In_Ready, (!m_full || Out_Ready)); else n_pass++;
         tick();
         n_checks++;
         if (Out_Valid !== m_full || Out_Digit !== 4'(m_digit) || Out_Err !== m_err || Display !== 7'(m_disp))
            $display("FAIL rand_outputs i=%0d: got vld=%b dig=%0d err=%b disp=%b want vld=%b dig=%0d err=%b disp=%b",
                     i, Out_Valid, Out_Digit, Out_Err, Display, m_full, m_digit, m_err, 7'(m_disp));
         else n_pass++;
`ifdef DECODIFICADOR_ERRCNT_EN
         n_checks++; if (Err_Count !== TB_ERR_W'(m_cnt)) $display("FAIL rand_err_count i=%0d: got %0d want %0d", i, Err_Count, m_cnt); else n_pass++;
`endif
      end
   endtask

`ifdef DECODIFICADOR_ERRCNT_EN
   task automatic test_err_count();
      for (int i = 0; i < 20; i++) begin
         apply(4'b1111, 1'b1, 1'b1);
         tick();
      end
      n_checks++; if (Err_Count !== 4'b1111) $display("FAIL err_count_saturate: got %b want 1111", Err_Count); else n_pass++;
   endtask
`endif

   task automatic test_reset_midfull();
      apply(4'b1000, 1'b1, 1'b1);
      tick();
      apply(4'b0100, 1'b1, 1'b0);
      tick();
      n_checks++; if (Display === 7'd0) $display("FAIL midreset_pre_display: got %b want nonblank", Display); else n_pass++;
      #2;
      Reset_n = 1'b0;
      #1;
      n_checks++; if (Out_Valid !== 1'b0) $display("FAIL midreset_out_valid: got %b want 0", Out_Valid); else n_pass++;
      n_checks++; if (Display !== 7'd0) $display("FAIL midreset_display: got %b want 0000000", Display); else n_pass++;
      n_checks++; if (In_Ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", In_Ready); else n_pass++;
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      model_reset();
      apply(4'd0, 1'b0, 1'b1);
      tick();
      n_checks++; if (Out_Valid !== 1'b0 || Display !== 7'd0) $display("FAIL midreset_discard: got vld=%b disp=%b want 0 0000000", Out_Valid, Display); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_stall();
      test_random();
`ifdef DECODIFICADOR_ERRCNT_EN
      test_err_count();
`endif
      test_reset_midfull();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
